// File: rtl/piso_serializer_pkg.sv
// piso_serializer_pkg: shared state encoding and idle line level for the serializer and its neighbours
package piso_serializer_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_e;
    localparam logic IDLE_BIT_DEF = 1'b0;
endpackage

// File: rtl/piso_serializer.sv
// piso_serializer: double-buffered parallel-in/serial-out stage with valid/ready input
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = IDLE_BIT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d, sh_q, sh_d;
    logic             hold_full_q, hold_full_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sout_q, sout_d, sv_q, sv_d;
    logic             last, load_sh, xfer;

    assign last       = cnt_q == LAST;
    assign load_sh    = hold_full_q & (state_q == ST_IDLE | last);
    assign din_ready  = !hold_full_q | load_sh;
    assign xfer       = din_valid & din_ready;
    assign busy       = hold_full_q | (state_q == ST_SHIFT);
    assign sout       = sout_q;
    assign sout_valid = sv_q;

    // hold register: refilled on any transfer, drained when the shifter takes it
    always_comb begin
        hold_d      = xfer ? din : hold_q;
        hold_full_d = xfer | (hold_full_q & !load_sh);
    end

    // shifter FSM: reload from hold, advance one bit per clock, or fall back to idle
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        sout_d  = sout_q;
        sv_d    = sv_q;
        if (load_sh) begin
            state_d = ST_SHIFT;
            sh_d    = hold_q;
            cnt_d   = '0;
            sout_d  = MSB_FIRST ? hold_q[WIDTH-1] : hold_q[0];
            sv_d    = 1'b1;
        end else if (state_q == ST_SHIFT && !last) begin
            sh_d   = MSB_FIRST ? sh_q << 1 : sh_q >> 1;
            cnt_d  = cnt_q + 1'b1;
            sout_d = MSB_FIRST ? sh_q[WIDTH-2] : sh_q[1];
        end else if (state_q == ST_SHIFT) begin
            state_d = ST_IDLE;
            sout_d  = IDLE_BIT;
            sv_d    = 1'b0;
        end
    end

    // state registers, cleared asynchronously so sout drops to idle at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            sh_q        <= '0;
            cnt_q       <= '0;
            sout_q      <= IDLE_BIT;
            sv_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            sout_q      <= sout_d;
            sv_q        <= sv_d;
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: randomized scoreboard bench for both bit orders of the serializer
module tb_piso_serializer;
    import piso_serializer_pkg::*;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         rdy_m, sout_m, sv_m, busy_m;
    logic         rdy_l, sout_l, sv_l, busy_l;
    int           checks = 0;
    int           fails = 0;
    int           e = 0;
    int           next_start = 0;
    logic         a;

    typedef struct {
        logic [W-1:0] w;
        int           start;
    } ent_t;
    ent_t q[$];

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_m),
        .sout(sout_m), .sout_valid(sv_m), .busy(busy_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_l),
        .sout(sout_l), .sout_valid(sv_l), .busy(busy_l)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, e, act, exp);
        end
    endtask

    // words occupy the line for W edges starting at their scheduled start edge
    task automatic purge();
        while (q.size() != 0 && q[0].start + W <= e) void'(q.pop_front());
    endtask

    // stage can accept at edge t unless some accepted word is still waiting to start after t
    function automatic logic model_ready(input int t);
        foreach (q[i]) if (q[i].start > t) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_out(output logic v, output logic bm, output logic bl);
        logic [W-1:0] w;
        int           idx;
        v  = 1'b0;
        bm = IDLE_BIT_DEF;
        bl = IDLE_BIT_DEF;
        foreach (q[i]) begin
            if (e >= q[i].start && e < q[i].start + W) begin
                idx = e - q[i].start;
                w   = q[i].w;
                v   = 1'b1;
                bm  = w[W-1-idx];
                bl  = w[idx];
            end
        end
    endtask

    task automatic cycle(input logic v, input logic [W-1:0] d, output logic acc);
        logic er, ev, em, el;
        int   s;
        din_valid = v;
        din       = d;
        er        = model_ready(e + 1);
        if (rst) begin
            check_eq("din_ready_msb", rdy_m, er);
            check_eq("din_ready_lsb", rdy_l, er);
        end
        acc = v && er && rst;
        @(posedge clk);
        e++;
        if (acc) begin
            s = (e + 1 > next_start) ? e + 1 : next_start;
            q.push_back('{w: d, start: s});
            next_start = s + W;
        end
        @(negedge clk);
        purge();
        model_out(ev, em, el);
        check_eq("sout_valid_msb", sv_m, ev);
        check_eq("sout_valid_lsb", sv_l, ev);
        check_eq("sout_msb", sout_m, em);
        check_eq("sout_lsb", sout_l, el);
        check_eq("busy_msb", busy_m, q.size() != 0);
        check_eq("busy_lsb", busy_l, q.size() != 0);
    endtask

    task automatic send(input logic [W-1:0] w);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            cycle(1'b1, w, acc);
            n++;
        end
        if (!acc) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: word %0h not taken after %0d cycles", w, n);
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        repeat (n) cycle(1'b0, W'($urandom), acc);
    endtask

    initial begin
        repeat (3) cycle(1'b1, 8'hA8, a);
        rst = 1'b1;
        idle(10);
        send(8'hA8);
        idle(10);
        send(8'hFF);
        send(8'h00);
        idle(12);
        send(8'h01);
        idle(10);
        repeat (40) begin
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            send(W'($urandom));
        end
        idle(20);
        send(8'hA5);
        idle(4);
        rst = 1'b0;
        #1;
        check_eq("async_rst_sout_valid_msb", sv_m, 1'b0);
        check_eq("async_rst_sout_valid_lsb", sv_l, 1'b0);
        check_eq("async_rst_sout_msb", sout_m, IDLE_BIT_DEF);
        check_eq("async_rst_busy_msb", busy_m, 1'b0);
        q.delete();
        next_start = 0;
        repeat (2) cycle(1'b1, 8'h3C, a);
        rst = 1'b1;
        send(8'h3C);
        idle(12);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
